// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges WB-stage and buffered MUL/DIV results into one registered regfile write per cycle.
module wb_write_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            pipe_valid_i,
  input  logic [4:0]                      pipe_rd_i,
  input  logic [XLEN-1:0]                 pipe_data_i,
  input  logic                            mdu_valid_i,
  output logic                            mdu_ready_o,
  input  logic [4:0]                      mdu_rd_i,
  input  logic [XLEN-1:0]                 mdu_data_i,
  input  logic                            issue_valid_i,
  input  logic [4:0]                      issue_rd_i,
  output logic [31:0]                     busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            w_ena_o,
  output logic [4:0]                      w_address_o,
  output logic [XLEN-1:0]                 w_data_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [4:0]      rd_mem [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            w_ena_q, w_ena_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            pipe_sel, push, pop;
  assign mdu_ready_o  = !rst_i && (count_q < CW'(FIFO_DEPTH));
  assign pipe_sel     = pipe_valid_i && (pipe_rd_i != 5'd0);
  assign push         = mdu_valid_i && mdu_ready_o && (mdu_rd_i != 5'd0);
  assign pop          = !pipe_sel && (count_q != '0);
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;
  assign w_ena_o      = w_ena_q;
  assign w_address_o  = w_addr_q;
  assign w_data_o     = w_data_q;
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    w_ena_d  = pipe_sel || pop;
    w_addr_d = pipe_sel ? pipe_rd_i : pop ? rd_mem[rd_ptr_q] : 5'd0;
    w_data_d = pipe_sel ? pipe_data_i : pop ? data_mem[rd_ptr_q] : '0;
    // clear first so a same-cycle issue to the popped register keeps it busy
    busy_d   = busy_q & ~(pop ? 32'd1 << rd_mem[rd_ptr_q] : 32'd0);
    busy_d   = busy_d | (issue_valid_i ? 32'd1 << issue_rd_i : 32'd0);
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      w_ena_q  <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      w_ena_q  <= w_ena_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= mdu_rd_i;
      data_mem[wr_ptr_q] <= mdu_data_i;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenario tests for wb_write_arbiter.
module tb_wb_write_arbiter;
  logic        clk = 1'b0;
  logic        rst, pipe_valid, mdu_valid, mdu_ready, issue_valid, w_ena;
  logic [4:0]  pipe_rd, mdu_rd, issue_rd, w_addr;
  logic [31:0] pipe_data, mdu_data, busy, w_data;
  logic [1:0]  fcount;
  int checks = 0, errors = 0;

  wb_write_arbiter #(.XLEN(32), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .pipe_valid_i(pipe_valid), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready), .mdu_rd_i(mdu_rd), .mdu_data_i(mdu_data),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .busy_o(busy), .fifo_count_o(fcount),
    .w_ena_o(w_ena), .w_address_o(w_addr), .w_data_o(w_data)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; pipe_valid = 0; pipe_rd = 0; pipe_data = 0; mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    issue_valid = 0; issue_rd = 0;
    step(); step();
    checks++; if ({w_ena, w_addr, w_data} !== 38'd0) begin errors++; $display("FAIL reset_wport got %b/%h/%h exp 0/00/00000000", w_ena, w_addr, w_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 00000000", busy); end
    checks++; if (fcount !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fcount); end
    checks++; if (mdu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", mdu_ready); end
    rst = 0; #1;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", mdu_ready); end
    step();
    checks++; if ({w_ena, busy} !== 33'd0) begin errors++; $display("FAIL post_reset_idle got %b/%h exp 0/00000000", w_ena, busy); end
  endtask

  task automatic test_pipe;
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    step();
    pipe_valid = 0;
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL pipe_x5 got %b/%0d/%h exp 1/5/deadbeef", w_ena, w_addr, w_data); end
    step();
    checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL pipe_one_cycle got %b exp 0", w_ena); end
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'h11111111;
    step();
    pipe_valid = 0;
    checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL pipe_x0_dropped got %b exp 0", w_ena); end
  endtask

  task automatic test_mdu;
    issue_valid = 1; issue_rd = 7;
    step();
    issue_valid = 0;
    checks++; if (busy !== 32'h80) begin errors++; $display("FAIL busy7_set got %h exp 00000080", busy); end
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h12345678;
    checks++; if (mdu_ready !== 1'b1) begin errors++; $display("FAIL mdu_ready got %b exp 1", mdu_ready); end
    step();
    mdu_valid = 0;
    checks++; if ({w_ena, fcount, busy[7]} !== {1'b0, 2'd1, 1'b1}) begin errors++; $display("FAIL mdu_no_bypass got ena %b cnt %0d busy7 %b exp 0 1 1", w_ena, fcount, busy[7]); end
    step();
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd7, 32'h12345678}) begin errors++; $display("FAIL mdu_x7 got %b/%0d/%h exp 1/7/12345678", w_ena, w_addr, w_data); end
    checks++; if ({busy, fcount} !== 34'd0) begin errors++; $display("FAIL busy7_clear got %h cnt %0d exp 00000000 0", busy, fcount); end
  endtask

  task automatic test_starve;
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'hA0;
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
    step();
    mdu_rd = 4; mdu_data = 32'h44;
    checks++; if (fcount !== 2'd1) begin errors++; $display("FAIL starve_cnt1 got %0d exp 1", fcount); end
    step();
    mdu_rd = 6; mdu_data = 32'h66;
    checks++; if ({mdu_ready, fcount} !== {1'b0, 2'd2}) begin errors++; $display("FAIL starve_full got ready %b cnt %0d exp 0 2", mdu_ready, fcount); end
    step();
    checks++; if ({mdu_ready, fcount, w_addr} !== {1'b0, 2'd2, 5'd1}) begin errors++; $display("FAIL starve_hold got ready %b cnt %0d addr %0d exp 0 2 1", mdu_ready, fcount, w_addr); end
    pipe_valid = 0;
    step();
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL drain_x3 got %b/%0d/%h exp 1/3/00000033", w_ena, w_addr, w_data); end
    checks++; if ({mdu_ready, fcount} !== {1'b1, 2'd1}) begin errors++; $display("FAIL drain_ready got %b cnt %0d exp 1 1", mdu_ready, fcount); end
    step();
    mdu_valid = 0;
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL drain_x4 got %b/%0d/%h exp 1/4/00000044", w_ena, w_addr, w_data); end
    checks++; if (fcount !== 2'd1) begin errors++; $display("FAIL push_pop_cnt got %0d exp 1", fcount); end
    step();
    checks++; if ({w_ena, w_addr, w_data, fcount} !== {1'b1, 5'd6, 32'h66, 2'd0}) begin errors++; $display("FAIL drain_x6 got %b/%0d/%h cnt %0d exp 1/6/00000066 0", w_ena, w_addr, w_data, fcount); end
    step();
    checks++; if (w_ena !== 1'b0) begin errors++; $display("FAIL drain_idle got %b exp 0", w_ena); end
  endtask

  task automatic test_priority;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'h1010;
    step();
    mdu_valid = 0;
    pipe_valid = 1; pipe_rd = 9; pipe_data = 32'h0909;
    step();
    pipe_valid = 0;
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd9, 32'h0909}) begin errors++; $display("FAIL prio_x9 got %b/%0d/%h exp 1/9/00000909", w_ena, w_addr, w_data); end
    step();
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd10, 32'h1010}) begin errors++; $display("FAIL prio_x10 got %b/%0d/%h exp 1/10/00001010", w_ena, w_addr, w_data); end
    mdu_valid = 1; mdu_rd = 11; mdu_data = 32'h1111;
    step();
    mdu_valid = 0;
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFF;
    step();
    pipe_valid = 0;
    checks++; if ({w_ena, w_addr, w_data} !== {1'b1, 5'd11, 32'h1111}) begin errors++; $display("FAIL x0_no_block got %b/%0d/%h exp 1/11/00001111", w_ena, w_addr, w_data); end
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h2222;
    step();
    mdu_valid = 0;
    checks++; if (fcount !== 2'd0) begin errors++; $display("FAIL mdu_x0_discard got %0d exp 0", fcount); end
  endtask

  task automatic test_set_clear;
    issue_valid = 1; issue_rd = 12;
    step();
    issue_valid = 0;
    mdu_valid = 1; mdu_rd = 12; mdu_data = 32'hC0C0;
    step();
    mdu_valid = 0;
    issue_valid = 1; issue_rd = 12;
    step();
    issue_valid = 0;
    checks++; if ({w_ena, w_addr} !== {1'b1, 5'd12}) begin errors++; $display("FAIL pop_x12 got %b/%0d exp 1/12", w_ena, w_addr); end
    checks++; if (busy !== 32'h1000) begin errors++; $display("FAIL set_wins got %h exp 00001000", busy); end
    issue_valid = 1; issue_rd = 0;
    step();
    issue_valid = 0;
    checks++; if (busy !== 32'h1000) begin errors++; $display("FAIL busy0_zero got %h exp 00001000", busy); end
  endtask

  task automatic test_reset_mid;
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'hB0;
    mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hD13;
    issue_valid = 1; issue_rd = 15;
    step();
    issue_valid = 0;
    mdu_rd = 14; mdu_data = 32'hD14;
    step();
    mdu_valid = 0;
    checks++; if ({fcount, busy} !== {2'd2, 32'h9000}) begin errors++; $display("FAIL pre_rst got cnt %0d busy %h exp 2 00009000", fcount, busy); end
    pipe_valid = 0; rst = 1;
    step();
    checks++; if ({w_ena, fcount, busy, mdu_ready} !== 36'd0) begin errors++; $display("FAIL mid_rst got ena %b cnt %0d busy %h rdy %b exp 0 0 0 0", w_ena, fcount, busy, mdu_ready); end
    rst = 0;
    step(); step();
    checks++; if ({w_ena, fcount, busy} !== 35'd0) begin errors++; $display("FAIL post_rst_idle got ena %b cnt %0d busy %h exp 0 0 0", w_ena, fcount, busy); end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_mdu();
    test_starve();
    test_priority();
    test_set_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
